// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the instruction fetch sequencer:
//   ADDR_W        - address / data width (32)
//   PC_INC        - sequential PC increment (one 32-bit word)
//   fetch_state_e - sequencer FSM states
//   word_align()  - clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        ISSUE      = 3'd1,
        WAIT       = 3'd2,
        HOLD       = 3'd3,
        ERROR      = 3'd4
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Instruction-memory fetch bus.
//   imem_req   - fetch request (master -> memory)
//   imem_addr  - fetch address  (master -> memory)
//   imem_ready - data returned this cycle (memory -> master)
//   imem_rdata - returned instruction word (memory -> master)
// Modports: master (the sequencer), slave (the instruction memory).
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timeout_counter.sv
// -----------------------------------------------------------------------------
// fetch_timeout_counter
// Counts consecutive cycles spent waiting on the instruction memory.
//   clk       - rising-edge clock
//   reset     - asynchronous, active-high
//   i_clear   - zero the count (has priority over i_enable)
//   i_enable  - count one missed cycle
//   o_expired - TIMEOUT_CYCLES-1 misses already counted: a further miss
//               this cycle is the timeout
// o_expired depends only on the registered count so the owning FSM can use
// it to decide its own enable without forming a combinational loop.
// -----------------------------------------------------------------------------
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Drives the PC register and sequences one instruction fetch at a time.
// Optional build macro: FETCH_ALIGN_CHECK_EN - a misaligned branch target
// raises fetch_err instead of being word-aligned and followed.
// Ports:
//   clk, reset        - clock; asynchronous active-high reset
//   i_pc_cur          - current PC register value
//   o_pc_next         - value loaded into the PC register every cycle
//   i_stall           - downstream hold, blocks new fetches
//   i_branch_taken    - one-cycle redirect pulse
//   i_branch_target   - redirect address
//   imem              - instruction memory bus (master side)
//   o_instr_valid     - one-cycle pulse with o_instr_out / o_instr_pc
//   o_instr_out       - fetched instruction word
//   o_instr_pc        - address of o_instr_out
//   o_fetch_err       - sticky timeout / misalignment error
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   i_pc_cur,
    output logic [ADDR_W-1:0]   o_pc_next,
    input  logic                i_stall,
    input  logic                i_branch_taken,
    input  logic [ADDR_W-1:0]   i_branch_target,
    fetch_sequencer_if.master   imem,
    output logic                o_instr_valid,
    output logic [ADDR_W-1:0]   o_instr_out,
    output logic [ADDR_W-1:0]   o_instr_pc,
    output logic                o_fetch_err
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_imem_req;
    logic              w_capture;
    logic              w_set_err;
    logic              w_cnt_clear;
    logic              w_cnt_enable;
    logic              w_cnt_expired;
    logic [ADDR_W-1:0] w_branch_addr;
    logic              w_branch_bad;

    logic              r_instr_valid;
    logic [ADDR_W-1:0] r_instr_out;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_fetch_err;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_branch_bad  = |i_branch_target[1:0];
    assign w_branch_addr = i_branch_target;
`else
    assign w_branch_bad  = 1'b0;
    assign w_branch_addr = word_align(i_branch_target);
`endif

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .o_expired (w_cnt_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESET_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = i_pc_cur;
        w_imem_req   = 1'b0;
        w_capture    = 1'b0;
        w_set_err    = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_enable = 1'b0;

        case (r_state)
            RESET_HOLD: begin
                w_pc_next    = RESET_VECTOR;
                w_state_next = ISSUE;
            end
            ISSUE: begin
                // A stall arriving before the request goes out parks the
                // sequencer instead of launching a fetch.
                if (i_stall) begin
                    w_state_next = HOLD;
                end else begin
                    w_imem_req   = 1'b1;
                    w_cnt_clear  = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_imem_req = 1'b1;
                if (imem.imem_ready) begin
                    // The word is accepted even when stalled; only the next
                    // request is held back.
                    w_capture    = 1'b1;
                    w_pc_next    = i_pc_cur + PC_INC;
                    w_state_next = i_stall ? HOLD : ISSUE;
                end else begin
                    w_cnt_enable = 1'b1;
                    if (w_cnt_expired) begin
                        w_set_err    = 1'b1;
                        w_state_next = ERROR;
                    end
                end
            end
            HOLD: begin
                if (!i_stall) begin
                    w_state_next = ISSUE;
                end
            end
            ERROR: begin
                w_state_next = ERROR;
            end
            default: begin
                w_state_next = RESET_HOLD;
            end
        endcase

        // A redirect overrides everything except a latched error; it also
        // discards an in-flight fetch, including one completing this cycle.
        if (r_state != ERROR && i_branch_taken) begin
            w_capture = 1'b0;
            if (w_branch_bad) begin
                w_set_err    = 1'b1;
                w_pc_next    = i_pc_cur;
                w_state_next = ERROR;
            end else begin
                w_set_err    = 1'b0;
                w_pc_next    = w_branch_addr;
                w_state_next = ISSUE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_valid <= 1'b0;
            r_instr_out   <= '0;
            r_instr_pc    <= '0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_instr_valid <= w_capture;
            if (w_capture) begin
                r_instr_out <= imem.imem_rdata;
                r_instr_pc  <= i_pc_cur;
            end
            if (w_set_err) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    assign o_pc_next      = w_pc_next;
    assign imem.imem_req  = w_imem_req;
    assign imem.imem_addr = i_pc_cur;
    assign o_instr_valid  = r_instr_valid;
    assign o_instr_out    = r_instr_out;
    assign o_instr_pc     = r_instr_pc;
    assign o_fetch_err    = r_fetch_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. The bench owns the PC register
// (loads pc_next every cycle) and plays the instruction memory. A fetch-level
// reference model predicts pc_next, the request, retired instructions and the
// error flag each cycle; directed scenarios add checks against fixed values.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_VECTOR   = 32'h0000_0000;
    localparam int          TIMEOUT_CYCLES = 16;
    localparam logic [31:0] PC_REG_RESET   = 32'hDEAD_BEE0;

    logic        clk;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fetch_err;

    fetch_sequencer_if imem_bus ();

    fetch_sequencer #(
        .RESET_VECTOR   (RESET_VECTOR),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_pc_cur        (pc_cur),
        .o_pc_next       (pc_next),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .imem            (imem_bus),
        .o_instr_valid   (instr_valid),
        .o_instr_out     (instr_out),
        .o_instr_pc      (instr_pc),
        .o_fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The PC register the sequencer steers.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_cur <= PC_REG_RESET;
        else       pc_cur <= pc_next;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (fetch-level view) ----------------
    logic        m_boot;    // first cycle after reset: load the reset vector
    logic        m_busy;    // a request is outstanding
    logic        m_parked;  // blocked by downstream stall
    logic        m_dead;    // error latched, only reset recovers
    logic        m_err;
    int          m_miss;    // consecutive cycles the outstanding request went unanswered
    logic [31:0] m_pc;      // what the PC register holds
    logic        m_vld;
    logic [31:0] m_ipc;
    logic [31:0] m_iout;

    // last sampled DUT outputs, for directed checks
    logic        s_req, s_vld, s_err;
    logic [31:0] s_addr, s_pcn, s_ipc;
    logic [31:0] vpcs[$];

    function automatic logic align_fault(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_boot = 1'b1; m_busy = 1'b0; m_parked = 1'b0; m_dead = 1'b0;
        m_err = 1'b0; m_miss = 0; m_pc = PC_REG_RESET;
        m_vld = 1'b0; m_ipc = '0; m_iout = '0;
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
        logic        e_req, cap, die, n_boot, n_busy, n_parked;
        logic [31:0] e_pcn, rd;
        int          n_miss;
        stall = st; branch_taken = br; branch_target = tgt;
        imem_bus.imem_ready = rdy;
        rd = $urandom();
        imem_bus.imem_rdata = rd;
        #1;
        e_req = 1'b0; e_pcn = m_pc; cap = 1'b0; die = 1'b0;
        n_boot = m_boot; n_busy = m_busy; n_parked = m_parked; n_miss = m_miss;
        if (!m_dead) begin
            if (m_boot) begin
                e_pcn = RESET_VECTOR; n_boot = 1'b0;
            end else if (m_parked) begin
                n_parked = st;
            end else if (!m_busy) begin
                if (st) n_parked = 1'b1;
                else begin e_req = 1'b1; n_busy = 1'b1; n_miss = 0; end
            end else begin
                e_req = 1'b1;
                if (rdy) begin
                    cap = 1'b1; e_pcn = m_pc + 32'd4; n_busy = 1'b0; n_parked = st;
                end else begin
                    n_miss = m_miss + 1;
                    if (n_miss >= TIMEOUT_CYCLES) begin die = 1'b1; n_busy = 1'b0; end
                end
            end
            if (br) begin
                cap = 1'b0; n_boot = 1'b0; n_busy = 1'b0; n_parked = 1'b0;
                if (align_fault(tgt)) begin die = 1'b1; e_pcn = m_pc; end
                else begin die = 1'b0; e_pcn = {tgt[31:2], 2'b00}; end
            end
        end
        s_req = imem_bus.imem_req; s_addr = imem_bus.imem_addr; s_pcn = pc_next;
        s_vld = instr_valid; s_ipc = instr_pc; s_err = fetch_err;
        check_eq("pc_next", pc_next, e_pcn);
        check_eq("imem_req", 32'(imem_bus.imem_req), 32'(e_req));
        if (e_req) check_eq("imem_addr", imem_bus.imem_addr, m_pc);
        check_eq("instr_valid", 32'(instr_valid), 32'(m_vld));
        if (m_vld) begin
            check_eq("instr_pc", instr_pc, m_ipc);
            check_eq("instr_out", instr_out, m_iout);
        end
        check_eq("fetch_err", 32'(fetch_err), 32'(m_err));
        if (instr_valid) begin
            vpcs.push_back(instr_pc);
            $display("fetch  pc=%08h instr=%08h", instr_pc, instr_out);
        end
        m_vld = cap;
        if (cap) begin m_ipc = m_pc; m_iout = rd; end
        m_err = m_err | die;
        m_dead = m_dead | die;
        m_pc = e_pcn; m_boot = n_boot; m_busy = n_busy; m_parked = n_parked; m_miss = n_miss;
        @(negedge clk);
    endtask

    // Asynchronous reset, asserted between clock edges; released on a falling edge.
    task automatic apply_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        #1;
        check_eq("rst_imem_req", 32'(imem_bus.imem_req), 32'd0);
        check_eq("rst_pc_next", pc_next, RESET_VECTOR);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr_out", instr_out, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
        check_eq("rst_fetch_err", 32'(fetch_err), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        imem_bus.imem_ready = 1'b0;
        vpcs.delete();
    endtask

    initial begin
        int cnt_req8, cnt_pcn8, cnt_vld8;
        logic        r_st, r_br, r_rdy;
        logic [31:0] r_tgt;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = '0;
        @(negedge clk);

        // Straight-line fetch, memory always ready.
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (c == 1) check_eq("seq_first_addr", s_addr, 32'h0);
        end
        check_eq("seq_count", 32'(vpcs.size()), 32'd4);
        for (int k = 0; k < 4 && k < vpcs.size(); k++)
            check_eq("seq_pc", vpcs[k], 32'(4 * k));

        // Memory answers late for the fetch at pc 8.
        apply_reset();
        cnt_req8 = 0; cnt_pcn8 = 0; cnt_vld8 = 0;
        for (int c = 0; c < 11; c++) begin
            step(1'b0, 1'b0, '0, (c < 5) || (c == 8));
            if (s_req && s_addr == 32'h8) cnt_req8++;
            if (s_pcn == 32'h8) cnt_pcn8++;
            if (s_vld && s_ipc == 32'h8) cnt_vld8++;
        end
        check_eq("late_req_cycles", 32'(cnt_req8), 32'd4);
        check_eq("late_pcn8_cycles", 32'(cnt_pcn8), 32'd4);
        check_eq("late_valid_count", 32'(cnt_vld8), 32'd1);

        // Branch coinciding with the memory answer.
        apply_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("br_no_valid", 32'(s_vld), 32'd0);
        check_eq("br_req", 32'(s_req), 32'd1);
        check_eq("br_addr", s_addr, 32'h100);

        // Stall for 5 cycles right after a fetch completes.
        apply_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, '0, 1'($urandom_range(0, 1)));
            check_eq("stall_req", 32'(s_req), 32'd0);
            check_eq("stall_pcn", s_pcn, 32'h4);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("stall_fall_req", 32'(s_req), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("stall_resume_req", 32'(s_req), 32'd1);
        check_eq("stall_resume_addr", s_addr, 32'h4);

        // Memory never answers.
        apply_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int c = 0; c < TIMEOUT_CYCLES; c++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            check_eq("to_err_early", 32'(s_err), 32'd0);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("to_err_set", 32'(s_err), 32'd1);
        for (int c = 0; c < 6; c++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h200, 1'b1);
            check_eq("to_err_sticky", 32'(s_err), 32'd1);
            check_eq("to_err_req", 32'(s_req), 32'd0);
        end

        // Misaligned branch target.
        apply_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'h102, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("mis_err", 32'(s_err), 32'd1);
        check_eq("mis_req", 32'(s_req), 32'd0);
`else
        check_eq("mis_err", 32'(s_err), 32'd0);
        check_eq("mis_addr", s_addr, 32'h100);
`endif

        // PC wrap at the top of the address space.
        apply_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("wrap_pcn", s_pcn, 32'h0);
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("wrap_addr", s_addr, 32'h0);
        check_eq("wrap_ipc", s_ipc, 32'hFFFF_FFFC);
        check_eq("wrap_err", 32'(s_err), 32'd0);

        // Reset while a fetch is outstanding, with the memory answering.
        apply_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("midrst_req_before", 32'(s_req), 32'd1);
        imem_bus.imem_ready = 1'b1;
        apply_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check_eq("midrst_no_valid", 32'(vpcs.size()), 32'd0);

        // Randomised traffic against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0 || (m_dead && $urandom_range(0, 39) == 0))
                apply_reset();
            r_st  = ($urandom_range(0, 3) == 0);
            r_br  = ($urandom_range(0, 15) == 0);
            r_tgt = $urandom();
            if ($urandom_range(0, 7) != 0) r_tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) r_tgt = 32'hFFFF_FFF0 | (r_tgt & 32'hF);
            r_rdy = ((i % 500) > 475) ? 1'b0 : 1'($urandom_range(0, 1));
            step(r_st, r_br, r_tgt, r_rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
